pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline stage register for the Y86 datapath.
- Replaces the fixed-field per-stage registers with one generic block: arbitrary payload width, valid/ready handshake, stall/bubble hazard control and a saturating stall counter.
- Instantiated between F/D/E/M/W stages; the hazard unit drives stall_i and bubble_i.

Parameters:
- DATA_W, 64, payload width in bits (packed icode/ifun/regs/valC/valP/dst fields).
- BUBBLE_VAL, 0, payload loaded on bubble (INOP encoding with RNONE destinations).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall_i  in  1  hold stage contents
- bubble_i  in  1  inject bubble, discard held contents
- cnt_clr_i  in  1  clear stall counter
- in_valid_i  in  1  upstream beat valid
- in_ready_o  out  1  stage can accept beat
- in_data_i  in  DATA_W  upstream payload
- out_valid_o  out  1  payload valid to downstream
- out_ready_i  in  1  downstream accepts
- out_data_o  out  DATA_W  payload to downstream
- stall_cnt_o  out  CNT_W  cycles with stall_i high, saturating

Behaviour:
- Reset: rst, synchronous, active-high; clock clk; all state on posedge clk.
- Values during and after reset:
  - valid_q=0, skid empty, out_data_o=BUBBLE_VAL, stall_cnt_o=0.
  - in_ready_o=0 while rst=1 and 1 on the first cycle after.
- Priority per cycle: rst > stall_i > bubble_i > handshake.
- Derived signals:
  - out_valid_o = valid_q && !stall_i (combinational gate).
  - in_fire = in_valid_i && in_ready_o.
  - out_fire = out_valid_o && out_ready_i.
- stall_i=1:
  - All payload and valid state frozen.
  - in_ready_o=0; out_valid_o=0, so no transfer occurs in either direction.
- bubble_i=1 (stall_i=0):
  - valid_q<=0, skid cleared, out_data_o<=BUBBLE_VAL.
  - in_ready_o=0; out_valid_o still reflects valid_q this cycle, and an out_fire in that cycle is legal.
  - bubble_i with valid_q=0 loads BUBBLE_VAL just the same.
- Normal, no skid (macro off):
  - in_ready_o = !stall_i && !bubble_i && (!valid_q || out_ready_i).
  - in_fire: out_data_o<=in_data_i, valid_q<=1.
  - out_fire without in_fire: valid_q<=0, out_data_o retained.
- Latency: 1 cycle from in_fire to out_valid_o.
- Throughput: 1 beat/cycle when out_ready_i is held high.
- stall_cnt_o:
  - Increments by 1 each cycle stall_i=1 and rst=0.
  - Holds at 2^CNT_W-1 (no wrap).
  - cnt_clr_i=1 forces 0 next cycle; clear wins over a simultaneous increment.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined: adds one skid entry (skid_q, skid_v).
  - in_ready_o = !stall_i && !bubble_i && !skid_v, so it has no combinational path from out_ready_i.
  - States: EMPTY (valid_q=0), ONE (valid_q=1, skid_v=0), TWO (both valid).
  - EMPTY + in_fire -> ONE.
  - ONE + in_fire && !out_fire -> TWO (beat stored in skid).
  - ONE + out_fire && !in_fire -> EMPTY.
  - ONE + both fire -> ONE with main <= new beat.
  - TWO + out_fire -> ONE with main <= skid (no input accepted).
  - Order is preserved at all times.
  - Bubble clears both entries -> EMPTY.
- Undefined: no skid logic; behaviour is exactly as described under Behaviour.

Test Plan:
- Reset, then in_valid_i=1 with data 0x0000_0000_0000_10A0 and out_ready_i=1:
  - out_valid_o=1 next cycle, out_data_o=0x...10A0.
  - Streaming 8 beats yields 8 consecutive out_fire cycles in order.
- Beat held, then stall_i=1 for 3 cycles:
  - out_valid_o=0 and in_ready_o=0 for those cycles; payload unchanged.
  - stall_cnt_o=3; after stall drops, the same payload is delivered once.
- bubble_i=1 with valid_q=1:
  - Next cycle out_valid_o=0 and out_data_o=BUBBLE_VAL.
  - A beat presented during the bubble is not accepted (in_ready_o=0).
- stall_i and bubble_i both high: stall wins and contents are unchanged; bubble is applied the cycle stall drops.
- Counter saturation with CNT_W=4:
  - 20 stall cycles -> stall_cnt_o=15.
  - cnt_clr_i together with stall_i -> 0.
- PIPE_STAGE_SKID_EN, out_ready_i=0, feed A then B:
  - A accepted, B accepted into skid, then in_ready_o=0.
  - Raising out_ready_i delivers A then B on consecutive cycles; in_ready_o returns to 1 after A leaves.
- rst asserted while in state TWO: next cycle out_valid_o=0, skid empty, out_data_o=BUBBLE_VAL.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- generic elastic pipeline stage register for the Y86 datapath.
//
// One payload register sits between two pipeline stages. It has a valid/ready
// handshake and is steered by the hazard unit through stall_i and bubble_i.
// It also keeps a saturating count of stalled cycles for performance analysis.
//
// Per-cycle priority: rst > stall_i > bubble_i > handshake.
//   stall_i  : freezes everything and blocks transfers in both directions.
//   bubble_i : discards the held contents and loads BUBBLE_VAL. A downstream
//              transfer in that same cycle still completes.
//
// Optional feature: define PIPE_STAGE_SKID_EN to add one skid entry. With the
// skid entry, in_ready_o no longer has a combinational path from out_ready_i.
// Without it, in_ready_o = !valid || out_ready_i.
//
// Parameters:
//   DATA_W     payload width in bits
//   BUBBLE_VAL payload loaded on reset and on bubble (INOP, RNONE destinations)
//   CNT_W      width of the stall counter
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   stall_i      hold stage contents
//   bubble_i     inject bubble, discard held contents
//   cnt_clr_i    clear stall counter (wins over a simultaneous increment)
//   in_valid_i   upstream beat valid
//   in_ready_o   stage can accept a beat
//   in_data_i    upstream payload
//   out_valid_o  payload valid to downstream
//   out_ready_i  downstream accepts
//   out_data_o   payload to downstream
//   stall_cnt_o  cycles with stall_i high, saturating at 2^CNT_W-1
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic              cnt_clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;

  // Downstream never sees a valid beat during a stall, so a stalled stage
  // cannot lose its payload to an out_fire.
  assign out_valid_o = r_valid && !stall_i;
  assign out_data_o  = r_data;
  assign in_ready_o  = w_in_ready;
  assign w_in_fire   = in_valid_i && w_in_ready;
  assign w_out_fire  = out_valid_o && out_ready_i;
  assign stall_cnt_o = r_stall_cnt;

`ifdef PIPE_STAGE_SKID_EN

  // Occupancy is decoded from the two valid flags. r_valid is always the
  // older beat, so r_data is always the head of the stage.
  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } skid_state_e;

  logic              r_skid_v;
  logic [DATA_W-1:0] r_skid_data;
  skid_state_e       w_state;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_state = S_EMPTY;
    if (r_skid_v)     w_state = S_TWO;
    else if (r_valid) w_state = S_ONE;
  end

  assign w_in_ready = !rst && !stall_i && !bubble_i && !r_skid_v;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_skid_v <= 1'b0;
      r_data   <= BUBBLE_VAL;
    end else if (!stall_i) begin
      if (bubble_i) begin
        r_valid  <= 1'b0;
        r_skid_v <= 1'b0;
        r_data   <= BUBBLE_VAL;
      end else begin
        case (w_state)
          S_EMPTY: begin
            if (w_in_fire) begin
              r_data  <= in_data_i;
              r_valid <= 1'b1;
            end
          end
          S_ONE: begin
            if (w_in_fire && w_out_fire) r_data   <= in_data_i;
            else if (w_in_fire)          r_skid_v <= 1'b1;
            else if (w_out_fire)         r_valid  <= 1'b0;
          end
          S_TWO: begin
            // The skid beat is younger, so it moves up once the head leaves.
            if (w_out_fire) begin
              r_data   <= r_skid_data;
              r_skid_v <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the skid payload is not reset. r_skid_v qualifies it, so its
  // contents are don't-care whenever the entry is empty.
  always_ff @(posedge clk) begin
    if (w_in_fire && (w_state == S_ONE) && !w_out_fire) r_skid_data <= in_data_i;
  end

`else

  assign w_in_ready = !rst && !stall_i && !bubble_i && (!r_valid || out_ready_i);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE_VAL;
    end else if (!stall_i) begin
      if (bubble_i) begin
        r_valid <= 1'b0;
        r_data  <= BUBBLE_VAL;
      end else if (w_in_fire) begin
        r_data  <= in_data_i;
        r_valid <= 1'b1;
      end else if (w_out_fire) begin
        // The payload is kept. Only the valid flag drops.
        r_valid <= 1'b0;
      end
    end
  end

`endif

  // Saturating stall counter. The clear wins over a simultaneous increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr_i) begin
      r_stall_cnt <= '0;
    end else if (stall_i && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg.
//
// The reference model is the ordered list of beats currently held by the
// stage, plus an integer stall count. The stimulus driver samples the
// handshake mid-cycle and updates the model at the clock edge: reset and
// bubble empty the list, and an accepted beat is appended. A separate monitor
// pops the list whenever the DUT presents a transfer and compares the payload.
// Expected ready/valid come from the list occupancy.
module tb_pipe_stage_reg;

  localparam int unsigned       DATA_W = 64;
  localparam int unsigned       CNT_W  = 4;
  localparam logic [DATA_W-1:0] BUB    = 64'h00FF_0000_0000_0010;
  localparam int                CNT_SAT = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_i;
  logic              bubble_i;
  logic              cnt_clr_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  pipe_stage_reg #(
    .DATA_W    (DATA_W),
    .BUBBLE_VAL(BUB),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .bubble_i   (bubble_i),
    .cnt_clr_i  (cnt_clr_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] exp_q[$];
  int                model_cnt = 0;
  int                n_cmp = 0;
  int                n_err = 0;

`ifdef PIPE_STAGE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle, with the inputs already applied. The checks happen at the
  // negedge, before the monitor pops, and the model update happens at the
  // posedge.
  task automatic cycle();
    bit                s_rst, s_stall, s_bub, s_clr, s_fire;
    logic [DATA_W-1:0] s_data;
    bit                exp_rdy;
    @(negedge clk);
    s_rst   = rst;
    s_stall = stall_i;
    s_bub   = bubble_i;
    s_clr   = cnt_clr_i;
    s_data  = in_data_i;
    s_fire  = in_valid_i && in_ready_o;
    // The stage accepts a beat only when it is free or the downstream is
    // draining it. With the skid entry, it accepts whenever it has room.
    if (DEPTH == 2) exp_rdy = (exp_q.size() < 2);
    else            exp_rdy = (exp_q.size() == 0) || out_ready_i;
    exp_rdy = exp_rdy && !s_rst && !s_stall && !s_bub;
    check("in_ready", 64'(in_ready_o), 64'(exp_rdy));
    if (!s_rst) begin
      check("out_valid", 64'(out_valid_o), 64'(exp_q.size() > 0 && !s_stall));
      check("stall_cnt", 64'(stall_cnt_o), 64'(model_cnt));
    end
    @(posedge clk);
    if (s_rst) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      if (s_clr)                             model_cnt = 0;
      else if (s_stall && model_cnt < CNT_SAT) model_cnt++;
      if (!s_stall) begin
        if (s_bub)       exp_q.delete();
        else if (s_fire) exp_q.push_back(s_data);
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit ordy,
                       input bit st, input bit bub, input bit clr, input bit r);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = ordy;
    stall_i     = st;
    bubble_i    = bub;
    cnt_clr_i   = clr;
    rst         = r;
    cycle();
  endtask

  // Monitor: pops the model list whenever the DUT presents a transfer.
  always begin
    @(negedge clk);
    #1;
    if (!rst && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(out_data_o), 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        check("out_data", out_data_o, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    drive(0, '0, 0, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 0, 1);
    check("reset_data", out_data_o, BUB);
    check("reset_cnt", 64'(stall_cnt_o), 64'd0);

    // First beat, then a stream of 8 beats with downstream always ready
    drive(1, 64'h0000_0000_0000_10A0, 1, 0, 0, 0, 0);
    check("first_valid", 64'(out_valid_o), 64'd1);
    check("first_data", out_data_o, 64'h0000_0000_0000_10A0);
    for (int i = 0; i < 8; i++) drive(1, 64'hB000 + 64'(i), 1, 0, 0, 0, 0);
    drive(0, '0, 1, 0, 0, 0, 0);

    // Held beat, then a 3-cycle stall
    drive(1, 64'h1111_2222_3333_4444, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 64'h5555, 1, 1, 0, 0, 0);
    check("stall_hold_data", out_data_o, 64'h1111_2222_3333_4444);
    check("stall_cnt_3", 64'(stall_cnt_o), 64'd3);
    drive(0, '0, 1, 0, 0, 0, 0);
    drive(0, '0, 1, 0, 0, 0, 0);

    // Bubble over a valid beat; a beat offered during the bubble is refused
    drive(1, 64'hAAAA, 0, 0, 0, 0, 0);
    drive(1, 64'hBBBB, 0, 0, 1, 0, 0);
    check("bubble_data", out_data_o, BUB);
    drive(0, '0, 1, 0, 0, 0, 0);

    // Stall and bubble together: the stall wins, and the bubble lands after
    drive(1, 64'hCCCC, 0, 0, 0, 0, 0);
    drive(0, '0, 1, 1, 1, 0, 0);
    drive(0, '0, 1, 1, 1, 0, 0);
    check("stall_over_bubble", out_data_o, 64'hCCCC);
    drive(0, '0, 0, 0, 1, 0, 0);
    check("bubble_after_stall", out_data_o, BUB);

    // Counter saturation and clear
    drive(0, '0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) drive(0, '0, 1, 1, 0, 0, 0);
    check("cnt_saturated", 64'(stall_cnt_o), 64'(CNT_SAT));
    drive(0, '0, 1, 1, 0, 1, 0);
    check("cnt_clear_wins", 64'(stall_cnt_o), 64'd0);

    // A then B (then C) with downstream blocked, then drain
    drive(1, 64'hA0A0, 0, 0, 0, 0, 0);
    drive(1, 64'hB0B0, 0, 0, 0, 0, 0);
    drive(1, 64'hC0C0, 0, 0, 0, 0, 0);
    check("head_is_A", out_data_o, 64'hA0A0);
    for (int i = 0; i < 3; i++) drive(0, '0, 1, 0, 0, 0, 0);

    // Reset while the stage is full
    drive(1, 64'hD1D1, 0, 0, 0, 0, 0);
    drive(1, 64'hD2D2, 0, 0, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 0, 1);
    check("rst_full_data", out_data_o, BUB);
    check("rst_full_valid", 64'(out_valid_o), 64'd0);
    drive(0, '0, 1, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 2) != 0), {$urandom, $urandom},
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 4; i++) drive(0, '0, 1, 0, 0, 0, 0);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
